// File: rtl/cmp_hysteresis_monitor.sv
// Debounced A-vs-B relation tracker for the 4-bit magnitude comparator flags.
// Define CMP_MON_TIMEOUT_EN to let an idle timer drop the relation back to UNKNOWN.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_UNKNOWN | no debounced relation yet (reset/clear/idle)
//   ST_ABOVE   | A > B held for DEBOUNCE legal samples
//   ST_BELOW   | A < B held for DEBOUNCE legal samples
//   ST_EQUAL   | A == B held for DEBOUNCE legal samples
module cmp_hysteresis_monitor #(
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             state_valid,
  output logic             change_pulse,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_ABOVE   = 2'b01,
    ST_BELOW   = 2'b10,
    ST_EQUAL   = 2'b11
  } state_t;

  localparam logic [3:0]       RUN_MAX = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  state_t           cand_q, cand_d;
  logic [3:0]       run_q, run_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, lt_cnt_q, lt_cnt_d, eq_cnt_q, eq_cnt_d;
  logic             err_q, err_d;
  logic             pulse_q, pulse_d;
  logic             valid_q;
  logic             legal;
  state_t           cls;

`ifdef CMP_MON_TIMEOUT_EN
  localparam int             TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_UNKNOWN;
      cand_q   <= ST_UNKNOWN;
      run_q    <= '0;
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
      err_q    <= 1'b0;
      pulse_q  <= 1'b0;
      valid_q  <= 1'b0;
`ifdef CMP_MON_TIMEOUT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      gt_cnt_q <= gt_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
      valid_q  <= (state_d != ST_UNKNOWN);
`ifdef CMP_MON_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  always_comb begin
    legal = 1'b0;
    cls   = ST_UNKNOWN;
    case ({gt, lt, eq})
      3'b100:  begin legal = in_valid; cls = ST_ABOVE; end
      3'b010:  begin legal = in_valid; cls = ST_BELOW; end
      3'b001:  begin legal = in_valid; cls = ST_EQUAL; end
      default: begin legal = 1'b0;     cls = ST_UNKNOWN; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    run_d    = run_q;
    gt_cnt_d = gt_cnt_q;
    lt_cnt_d = lt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    err_d    = err_q;
    pulse_d  = 1'b0;
`ifdef CMP_MON_TIMEOUT_EN
    timer_d  = timer_q;
`endif
    if (clear) begin
      state_d  = ST_UNKNOWN;
      cand_d   = ST_UNKNOWN;
      run_d    = '0;
      gt_cnt_d = '0;
      lt_cnt_d = '0;
      eq_cnt_d = '0;
      err_d    = 1'b0;
`ifdef CMP_MON_TIMEOUT_EN
      timer_d  = '0;
`endif
    end else begin
      if (in_valid && !legal) err_d = 1'b1;
      if (legal) begin
        case (cls)
          ST_ABOVE: if (gt_cnt_q != CNT_MAX) gt_cnt_d = gt_cnt_q + CNT_W'(1);
          ST_BELOW: if (lt_cnt_q != CNT_MAX) lt_cnt_d = lt_cnt_q + CNT_W'(1);
          default:  if (eq_cnt_q != CNT_MAX) eq_cnt_d = eq_cnt_q + CNT_W'(1);
        endcase
        // Candidate is UNKNOWN only after reset/clear/timeout, so it never matches a legal class.
        if (cls == cand_q) begin
          if (run_q != RUN_MAX) run_d = run_q + 4'd1;
        end else begin
          cand_d = cls;
          run_d  = 4'd1;
        end
        if (run_d == RUN_MAX && cand_d != state_q) begin
          state_d = cand_d;
          pulse_d = 1'b1;
        end
      end
`ifdef CMP_MON_TIMEOUT_EN
      if (legal) begin
        timer_d = '0;
      end else if (timer_q != TMR_MAX) begin
        timer_d = timer_q + TMR_W'(1);
        if (timer_d == TMR_MAX && state_q != ST_UNKNOWN) begin
          state_d = ST_UNKNOWN;
          cand_d  = ST_UNKNOWN;
          run_d   = '0;
          pulse_d = 1'b1;
        end
      end
`endif
    end
  end

  assign state        = state_q;
  assign state_valid  = valid_q;
  assign change_pulse = pulse_q;
  assign gt_cnt       = gt_cnt_q;
  assign lt_cnt       = lt_cnt_q;
  assign eq_cnt       = eq_cnt_q;
  assign err          = err_q;

endmodule

// File: doc/cmp_hysteresis_monitor.md
Name: cmp_hysteresis_monitor

Overview:
- Sits directly downstream of the 4-bit magnitude comparator and consumes its gt/lt/eq flags one sample per valid cycle.
- Filters the flags with a consecutive-sample debounce so that a single glitchy compare cannot change the reported relation.
- Tracks the debounced A-vs-B relation in a small state machine and reports it.
- Keeps saturating per-outcome counters and a sticky error for illegal flag combinations.

Parameters:
- CNT_W, 8: width of each outcome counter.
- DEBOUNCE, 3: consecutive identical legal samples needed to change state. Legal range is 1 to 15.
- TIMEOUT, 16: idle cycles before the state reverts to UNKNOWN. Used only when CMP_MON_TIMEOUT_EN is defined.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: gt/lt/eq carry a sample this cycle.
- gt, input, 1: comparator A>B flag.
- lt, input, 1: comparator A<B flag.
- eq, input, 1: comparator A==B flag.
- clear, input, 1: synchronous soft clear.
- state, output, 2: debounced relation. 00=UNKNOWN, 01=ABOVE, 10=BELOW, 11=EQUAL.
- state_valid, output, 1: high when state != UNKNOWN.
- change_pulse, output, 1: one-cycle pulse when state changes.
- gt_cnt, output, CNT_W: count of legal gt samples.
- lt_cnt, output, CNT_W: count of legal lt samples.
- eq_cnt, output, CNT_W: count of legal eq samples.
- err, output, 1: sticky illegal-flag indicator.

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n).
  - rst_n low immediately forces all outputs to 0: state=00, state_valid=0, change_pulse=0, all counters 0, err=0.
  - Internal candidate class, run counter and idle timer also go to 0.
  - Reset asserted mid-operation aborts any debounce in progress with no residue.
- All outputs are registered. Each sample takes effect on the clk edge where in_valid=1.
- Legal sample: exactly one of gt/lt/eq is high. Its class is ABOVE, BELOW or EQUAL respectively.
- Illegal sample (zero or more than one flag high, with in_valid=1):
  - err sets to 1 and stays set until clear or reset.
  - The sample is otherwise ignored: counters, candidate, run and state are unchanged.
  - It does not break a run of identical samples.
- Counters: a legal sample increments its class counter, saturating at 2^CNT_W-1 with no wrap.
- Debounce:
  - If the class equals the candidate, run increments, saturating at DEBOUNCE.
  - Otherwise candidate becomes the class and run becomes 1.
- State transition:
  - On the edge that accepts the sample bringing run to DEBOUNCE, if candidate != state, state takes the candidate on that same edge.
  - change_pulse is 1 for exactly the following cycle.
  - Latency is DEBOUNCE accepted samples. With DEBOUNCE=1 every legal sample updates state immediately.
- No change_pulse when the debounced class equals the current state.
- in_valid=0: no change to any register except the optional idle timer. Gaps do not break a run.
- clear=1:
  - On the next edge, returns every register to its reset value.
  - clear has priority over in_valid in the same cycle; that sample is dropped and not counted.
  - clear does not generate change_pulse.
- Simultaneous event: a legal sample that both saturates its counter and completes a debounce performs both actions.

Optional Feature:
- Macro: CMP_MON_TIMEOUT_EN.
- Defined:
  - An idle timer counts cycles with no legal accepted sample and resets to 0 on every legal sample.
  - Illegal samples do not reset the timer.
  - When the timer reaches TIMEOUT while state != UNKNOWN, state returns to 00 and candidate/run clear on that edge; change_pulse is 1 for the next cycle.
  - The timer holds at TIMEOUT until the next legal sample.
- Not defined: no timer logic, the TIMEOUT parameter is unused, and state persists indefinitely without samples.

Test Plan (DEBOUNCE=3, CNT_W=8, TIMEOUT=16):
- Reset: hold rst_n=0 with random inputs toggling, then release -> all outputs 0. Assert rst_n=0 mid-run after 2 gt samples -> outputs 0 immediately. After release, one more gt sample -> state stays 00.
- Three valid gt samples (A=0010, B=0001 gives flags 100) -> state=01 after the 3rd edge, change_pulse high for one cycle, gt_cnt=3, state_valid=1.
- From ABOVE, apply lt, lt, eq, lt, lt, lt -> state stays 01 until the 6th sample, then becomes 10 with one change_pulse. Final lt_cnt=5, eq_cnt=1.
- Apply gt, gt, illegal (gt=1, lt=1), idle cycle, gt -> err=1 sticky, gt_cnt=3, state=01 after the 4th valid cycle.
- 300 consecutive eq samples -> eq_cnt=255 (saturated), state=11, exactly one change_pulse. Then clear=1 together with an in_valid lt sample -> all outputs 0, lt_cnt=0.
- With CMP_MON_TIMEOUT_EN: reach ABOVE, then idle for 16 cycles -> state=00, one change_pulse. Without the macro, the same stimulus -> state stays 01.
